ga_fitness_accumulator: RTL
===========================

Name: ga_fitness_accumulator

Overview:
- Synthesizable fitness scorer for the grammatical-evolution hardware flow. It replaces the per-generation simulation-only scoring loop.
- Each cycle it takes one test vector's expected output word plus the actual outputs of NUM_IND candidate circuits.
- Per candidate, it accumulates the bitwise match (or mismatch) count across all NUM_VEC vectors.
- It then streams one score per candidate over a valid/ready port, indexed so the host can rank the population.

Parameters:
- NUM_IND, 15, number of candidate individuals scored in parallel
- NUM_OUT, 4, output ports per individual
- OUT_W, 16, width of each output port
- NUM_VEC, 16, test vectors per evaluation run (>=1)
- ACC_W, 16, score accumulator width; saturating

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-low
- start  in  1  begin evaluation; honoured only in IDLE
- mode  in  1  sampled at accepted start: 0 = count matching bits, 1 = count mismatching bits
- vec_valid  in  1  expected/actual buses hold a valid vector
- vec_ready  out  1  block accepts a vector this cycle
- expected  in  NUM_OUT*OUT_W  golden outputs; port k at bits [k*OUT_W +: OUT_W]
- actual  in  NUM_IND*NUM_OUT*OUT_W  candidate outputs; individual i at [i*NUM_OUT*OUT_W +: NUM_OUT*OUT_W]
- busy  out  1  high in RUN and REPORT
- res_valid  out  1  result presented
- res_ready  in  1  consumer takes result
- res_index  out  $clog2(NUM_IND) (min 1)  individual index of the presented result
- res_fitness  out  ACC_W  accumulated score
- res_perfect  out  1  score == NUM_VEC*NUM_OUT*OUT_W (mode 0) or == 0 (mode 1)
- done  out  1  one-cycle pulse after the final result handshake

Behaviour:
- Reset (rst==0 at posedge) has priority over everything, including mid-RUN and mid-REPORT.
  - State goes to IDLE.
  - Accumulators, vector counter, result index, stored mode, res_valid, done and busy all clear to 0.
  - vec_ready goes to 0.
- States: IDLE, RUN, REPORT.
- IDLE:
  - vec_ready=0, busy=0, res_valid=0.
  - On start==1: clear all accumulators and the vector counter, latch mode, and go to RUN next cycle.
  - vec_valid is ignored.
- RUN:
  - vec_ready=1, busy=1.
  - A vector is accepted on a posedge where vec_valid&&vec_ready. On acceptance, for every i: acc[i] += popcount(~(expected ^ actual_i)) in mode 0, or popcount(expected ^ actual_i) in mode 1.
  - The per-vector contribution is 0..NUM_OUT*OUT_W. The add saturates at 2^ACC_W-1.
  - Vector counter increments on each acceptance.
  - Accepting vector NUM_VEC-1 moves the state to REPORT next cycle, with vec_ready=0 in REPORT.
  - Cycles with vec_valid=0 change nothing.
  - start is ignored in RUN and REPORT.
- REPORT:
  - busy=1, res_valid=1.
  - res_index = idx, res_fitness = acc[idx], res_perfect derived from acc[idx] and the latched mode.
  - Outputs are held stable while res_ready==0.
  - On res_valid&&res_ready: idx increments, and the next result appears the following cycle.
  - On the handshake with idx==NUM_IND-1: go to IDLE, assert done for exactly one cycle; res_valid=0 that cycle.
- Accumulators keep their final values in IDLE until the next accepted start.
- Throughput: one vector per cycle in RUN, one result per cycle in REPORT when res_ready is held high.
- Minimum run from start to done: 1 + NUM_VEC + NUM_IND cycles.

Test Plan (bench params NUM_IND=3, NUM_OUT=1, OUT_W=4, NUM_VEC=2, ACC_W=8, unless noted):
- Mode 0, expected 4'b1010 then 4'b0110; ind0 exact, ind1 bit-inverted, ind2 LSB flipped both vectors -> results (0,8,perfect=1), (1,0,0), (2,6,0), then done pulse one cycle later.
- Same stimulus in mode 1 -> fitness 0/8/2; res_perfect=1 only for index 0.
- vec_valid low for 2 cycles between vectors and res_ready low 3 cycles on index 1 -> same scores; res_index=1 and res_fitness held steady throughout the stall; vec_ready=0 after the second vector.
- ACC_W=3 with ind0 exact -> res_fitness saturates at 7, not 0.
- start pulsed during RUN and REPORT -> ignored, scores unchanged. rst=0 after the first vector -> all outputs 0, state IDLE; a fresh start then gives the scores of the first scenario.
- Back-to-back runs: start the cycle after done with new vectors -> accumulators cleared, no carry-over from the prior run.

Source files
------------

// File: rtl/ga_fitness_accumulator.sv
// Parallel fitness scorer: accumulates per-candidate bit match/mismatch counts over
// NUM_VEC test vectors, then streams one score per candidate over valid/ready.
module ga_fitness_accumulator #(
    parameter int unsigned NUM_IND = 15,
    parameter int unsigned NUM_OUT = 4,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned ACC_W   = 16,
    localparam int unsigned IDX_W  = (NUM_IND > 1) ? $clog2(NUM_IND) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             mode,
    input  logic                             vec_valid,
    output logic                             vec_ready,
    input  logic [NUM_OUT*OUT_W-1:0]         expected,
    input  logic [NUM_IND*NUM_OUT*OUT_W-1:0] actual,
    output logic                             busy,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [IDX_W-1:0]                 res_index,
    output logic [ACC_W-1:0]                 res_fitness,
    output logic                             res_perfect,
    output logic                             done
);

    localparam int unsigned VW      = NUM_OUT * OUT_W;
    localparam int unsigned CNT_W   = $clog2(VW + 1);
    localparam int unsigned SUM_W   = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam int unsigned VC_W    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int unsigned PW      = (ACC_W > 32) ? ACC_W : 32;
    localparam int unsigned PERFECT = NUM_VEC * VW;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [VC_W-1:0]    vcnt_q, vcnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   acc_q [NUM_IND];
    logic [ACC_W-1:0]   acc_d [NUM_IND];
    logic               vec_ready_q, vec_ready_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;
    logic               done_q, done_d;
    logic [SUM_W-1:0]   sum;
    logic [VW-1:0]      diff;

    function automatic logic [CNT_W-1:0] popcount(input logic [VW-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned b = 0; b < VW; b++) c += CNT_W'(v[b]);
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        vcnt_d      = vcnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        vec_ready_d = vec_ready_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;
        sum         = '0;
        diff        = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    mode_d      = mode;
                    vcnt_d      = '0;
                    idx_d       = '0;
                    for (int unsigned i = 0; i < NUM_IND; i++) acc_d[i] = '0;
                    vec_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    res_valid_d = 1'b0;
                end
            end
            S_RUN: begin
                if (vec_valid) begin
                    // Saturating add: sum is one bit wider than either operand, so it cannot wrap.
                    for (int unsigned i = 0; i < NUM_IND; i++) begin
                        diff = expected ^ actual[i*VW +: VW];
                        if (!mode_q) diff = ~diff;
                        sum = SUM_W'(acc_q[i]) + SUM_W'(popcount(diff));
                        acc_d[i] = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(sum);
                    end
                    vcnt_d = vcnt_q + 1'b1;
                    if (vcnt_q == VC_W'(NUM_VEC - 1)) begin
                        state_d     = S_REPORT;
                        idx_d       = '0;
                        vec_ready_d = 1'b0;
                        res_valid_d = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    if (idx_q == IDX_W'(NUM_IND - 1)) begin
                        state_d     = S_IDLE;
                        busy_d      = 1'b0;
                        res_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                vec_ready_d = 1'b0;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            vcnt_q      <= '0;
            idx_q       <= '0;
            for (int unsigned i = 0; i < NUM_IND; i++) acc_q[i] <= '0;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            vcnt_q      <= vcnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            vec_ready_q <= vec_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        res_fitness = '0;
        for (int unsigned i = 0; i < NUM_IND; i++)
            if (idx_q == IDX_W'(i)) res_fitness = acc_q[i];
    end

    assign res_perfect = mode_q ? (res_fitness == '0)
                                : (PW'(res_fitness) == PW'(PERFECT));
    assign res_index   = idx_q;
    assign vec_ready   = vec_ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign done        = done_q;

endmodule
